// File: rtl/sump_pkg.sv
// Shared SUMP definitions: decoder state encoding and protocol opcodes.
package sump_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } dec_state_t;

  localparam logic [7:0] OP_RESET      = 8'h00;
  localparam logic [7:0] OP_RUN        = 8'h01;
  localparam logic [7:0] OP_ID         = 8'h02;
  localparam logic [7:0] OP_META       = 8'h04;
  localparam logic [7:0] OP_DIVIDER    = 8'h80;
  localparam logic [7:0] OP_READ_DELAY = 8'h81;
  localparam logic [7:0] OP_FLAGS      = 8'h82;
  localparam logic [7:0] OP_TRIG_MASK  = 8'hC0;
  localparam logic [7:0] OP_TRIG_VALUE = 8'hC1;

  localparam int LONG_CMD_BIT = 7;

  // Long commands carry four argument bytes after the opcode.
  function automatic logic is_long_cmd(input logic [7:0] op);
    return op[LONG_CMD_BIT];
  endfunction

endpackage

// File: rtl/sump_cmd_decoder_if.sv
// Byte stream from the UART receiver in, assembled command to the controller out.
interface sump_cmd_decoder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_frame_err;
  logic [7:0]  opcode;
  logic [31:0] command;
  logic        cmd_recv_rx;
  logic        cmd_abort;
  logic        busy;

  modport master (
    output rx_data, rx_valid, rx_frame_err,
    input  opcode, command, cmd_recv_rx, cmd_abort, busy
  );

  modport slave (
    input  rx_data, rx_valid, rx_frame_err,
    output opcode, command, cmd_recv_rx, cmd_abort, busy
  );
endinterface

// File: rtl/sump_byte_timer.sv
// Loadable saturating idle counter; expired is high while the count sits at LIMIT-1.
module sump_byte_timer #(
  parameter int LIMIT = 1000000,
  parameter int WIDTH = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
  input  logic clock,
  input  logic ext_reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LIMIT_M1 = WIDTH'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [WIDTH-1:0] timer;

  always_ff @(posedge clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable && (timer != {WIDTH{1'b1}})) begin
      timer <= timer + 1'b1;
    end
  end

  // A limit of zero turns the timeout off entirely.
  generate
    if (LIMIT == 0) begin : g_no_limit
      assign expired = 1'b0;
    end else begin : g_limit
      assign expired = (timer == LIMIT_M1);
    end
  endgenerate

endmodule

// File: rtl/sump_cmd_decoder.sv
// Assembles short (1-byte) and long (opcode + 4 LSB-first bytes) SUMP commands.
module sump_cmd_decoder
  import sump_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMER_WIDTH    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input logic clock,
  input logic ext_reset_n,
  sump_cmd_decoder_if.slave bus
);

  dec_state_t  state;
  logic [7:0]  op_w;
  logic [31:0] arg_w;
  logic [1:0]  byte_cnt;
  logic [7:0]  opcode_reg;
  logic [31:0] command_reg;
  logic        cmd_recv_reg;
  logic        cmd_abort_reg;
  logic        busy_reg;
  logic        timer_expired;

  // Any received byte restarts the gap timer, so a byte on the expiry cycle wins.
  sump_byte_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (TIMER_WIDTH)
  ) u_timer (
    .clock       (clock),
    .ext_reset_n (ext_reset_n),
    .clear       (bus.rx_valid),
    .enable      (state == ST_COLLECT),
    .expired     (timer_expired)
  );

  always_ff @(posedge clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state         <= ST_IDLE;
      op_w          <= '0;
      arg_w         <= '0;
      byte_cnt      <= '0;
      opcode_reg    <= '0;
      command_reg   <= '0;
      cmd_recv_reg  <= 1'b0;
      cmd_abort_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      cmd_recv_reg  <= 1'b0;
      cmd_abort_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.rx_valid && !bus.rx_frame_err) begin
            if (is_long_cmd(bus.rx_data)) begin
              op_w     <= bus.rx_data;
              arg_w    <= '0;
              byte_cnt <= '0;
              busy_reg <= 1'b1;
              state    <= ST_COLLECT;
            end else begin
              opcode_reg   <= bus.rx_data;
              command_reg  <= '0;
              cmd_recv_reg <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (bus.rx_valid) begin
            if (bus.rx_frame_err) begin
              cmd_abort_reg <= 1'b1;
              busy_reg      <= 1'b0;
              state         <= ST_IDLE;
            end else if (byte_cnt == 2'd3) begin
              opcode_reg   <= op_w;
              command_reg  <= {bus.rx_data, arg_w[23:0]};
              cmd_recv_reg <= 1'b1;
              busy_reg     <= 1'b0;
              state        <= ST_IDLE;
            end else begin
              arg_w[8*byte_cnt +: 8] <= bus.rx_data;
              byte_cnt               <= byte_cnt + 2'd1;
            end
          end else if (timer_expired) begin
            cmd_abort_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.opcode      = opcode_reg;
  assign bus.command     = command_reg;
  assign bus.cmd_recv_rx = cmd_recv_reg;
  assign bus.cmd_abort   = cmd_abort_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Directed bench: stimulus pushes expected pulses into a queue, a negedge monitor pops and compares.
module tb_sump_cmd_decoder;

  logic clock = 1'b0;
  logic ext_reset_n = 1'b0;
  int   cycle_cnt = 0;
  int   total = 0;
  int   passed = 0;
  int   drv_cyc = 0;

  typedef struct {
    bit          is_abort;
    logic [7:0]  op;
    logic [31:0] cmd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  sump_cmd_decoder_if bus ();

  sump_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .ext_reset_n (ext_reset_n),
    .bus         (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle_cnt);
  endfunction

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.cmd_recv_rx || bus.cmd_abort) begin
      check("pulse_exclusive", 32'(bus.cmd_recv_rx & bus.cmd_abort), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, bus.cmd_abort, bus.cmd_recv_rx}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("pulse %s op=%02h cmd=%08h cycle=%0d", bus.cmd_abort ? "abort" : "recv",
                 bus.opcode, bus.command, cycle_cnt);
        check("pulse_kind_abort", 32'(bus.cmd_abort), 32'(e.is_abort));
        check("opcode", 32'(bus.opcode), 32'(e.op));
        check("command", bus.command, e.cmd);
        check("pulse_cycle", cycle_cnt, e.cyc);
      end
    end
  end

  task automatic drive_byte(input logic [7:0] d, input logic err);
    @(negedge clock);
    bus.rx_data      = d;
    bus.rx_valid     = 1'b1;
    bus.rx_frame_err = err;
    drv_cyc          = cycle_cnt;
    $display("rx byte %02h err=%0d cycle=%0d", d, err, drv_cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.rx_valid     = 1'b0;
      bus.rx_frame_err = 1'b0;
    end
  endtask

  task automatic expect_pulse(input bit ab, input logic [7:0] op, input logic [31:0] cmd,
                              input int cyc);
    exp_t e;
    e.is_abort = ab;
    e.op       = op;
    e.cmd      = cmd;
    e.cyc      = cyc;
    exp_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_opcode"}, 32'(bus.opcode), 32'd0);
    check({tag, "_command"}, bus.command, 32'd0);
    check({tag, "_recv"}, 32'(bus.cmd_recv_rx), 32'd0);
    check({tag, "_abort"}, 32'(bus.cmd_abort), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    bus.rx_data      = 8'h00;
    bus.rx_valid     = 1'b0;
    bus.rx_frame_err = 1'b0;

    // Reset held with bytes arriving: nothing may come out.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus.rx_valid = ~bus.rx_valid;
      bus.rx_data  = (i % 2 == 0) ? 8'h02 : 8'h80;
      #1 check_outputs_zero("in_reset");
    end
    idle(1);
    ext_reset_n = 1'b1;
    idle(2);

    drive_byte(8'h02, 1'b0);
    expect_pulse(1'b0, 8'h02, 32'h0, drv_cyc + 1);
    idle(2);

    // Spaced long command with busy tracking.
    drive_byte(8'h80, 1'b0);
    idle(1);
    check("busy_after_opcode", 32'(bus.busy), 32'd1);
    idle(3);
    drive_byte(8'h10, 1'b0); idle(4);
    drive_byte(8'h27, 1'b0); idle(4);
    drive_byte(8'h00, 1'b0); idle(4);
    check("busy_before_last", 32'(bus.busy), 32'd1);
    drive_byte(8'h00, 1'b0);
    expect_pulse(1'b0, 8'h80, 32'h00002710, drv_cyc + 1);
    idle(1);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    idle(2);

    // Stalled long command times out; outputs keep the last command.
    drive_byte(8'hC0, 1'b0); idle(1);
    drive_byte(8'hAA, 1'b0); idle(1);
    drive_byte(8'hBB, 1'b0);
    expect_pulse(1'b1, 8'h80, 32'h00002710, drv_cyc + 17);
    idle(20);
    check("busy_after_timeout", 32'(bus.busy), 32'd0);

    // Framing error in IDLE is dropped silently.
    drive_byte(8'h05, 1'b1); idle(3);

    // Framing error mid-command aborts; next clean byte decodes.
    drive_byte(8'hC1, 1'b0); idle(1);
    drive_byte(8'h01, 1'b0); idle(1);
    drive_byte(8'h02, 1'b1);
    expect_pulse(1'b1, 8'h80, 32'h00002710, drv_cyc + 1);
    idle(1);
    drive_byte(8'h04, 1'b0);
    expect_pulse(1'b0, 8'h04, 32'h0, drv_cyc + 1);
    idle(2);

    // Back-to-back bytes, with a short command right after completion.
    drive_byte(8'h82, 1'b0);
    drive_byte(8'h01, 1'b0);
    drive_byte(8'h02, 1'b0);
    drive_byte(8'h03, 1'b0);
    drive_byte(8'h04, 1'b0);
    expect_pulse(1'b0, 8'h82, 32'h04030201, drv_cyc + 1);
    drive_byte(8'h00, 1'b0);
    expect_pulse(1'b0, 8'h00, 32'h0, drv_cyc + 1);
    idle(2);

    // Five SUMP reset bytes give five pulses.
    for (int i = 0; i < 5; i++) begin
      drive_byte(8'h00, 1'b0);
      expect_pulse(1'b0, 8'h00, 32'h0, drv_cyc + 1);
    end
    idle(2);

    // Reset mid-collection: silent discard, then clean decode.
    drive_byte(8'h81, 1'b0); idle(1);
    drive_byte(8'h11, 1'b0); idle(1);
    drive_byte(8'h22, 1'b0); idle(1);
    ext_reset_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    idle(2);
    ext_reset_n = 1'b1;
    idle(1);
    drive_byte(8'h01, 1'b0);
    expect_pulse(1'b0, 8'h01, 32'h0, drv_cyc + 1);
    idle(1);

    // Drain: all expected pulses must have arrived within a bounded wait.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    idle(20);
    check("no_late_pulses", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
